// File: rtl/tm1638_page_sched.sv
// Page scheduler for the shared TM1638 panel: round-robin between two sources
// with a minimum on-screen hold, falling back to the default student-ID page.
module tm1638_page_sched #(
    parameter logic [31:0] DEFAULT_DIGITS = 32'h6619_1122,
    parameter logic [7:0]  DEFAULT_LED    = 8'h00,
    parameter int unsigned MIN_HOLD       = 4
) (
    input  logic        _50MHz_CLK,
    input  logic        RST,
    input  logic        tick_in,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [31:0] dig_a,
    input  logic [31:0] dig_b,
    input  logic [7:0]  led_a,
    input  logic [7:0]  led_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [1:0]  page,
    output logic        page_chg,
    output logic [3:0]  seg0,
    output logic [3:0]  seg1,
    output logic [3:0]  seg2,
    output logic [3:0]  seg3,
    output logic [3:0]  seg4,
    output logic [3:0]  seg5,
    output logic [3:0]  seg6,
    output logic [3:0]  seg7,
    output logic [7:0]  led
);

    localparam int unsigned HOLD_W   = 8;
    localparam int unsigned DIGITS_W = 32;
    localparam int unsigned LED_W    = 8;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A    = 2'd1,
        ST_B    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_last_b;
    logic [HOLD_W-1:0]   r_hold;
    logic                w_expired;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_tick_d;
    logic                w_tick;

    logic                r_chg;
    logic                r_gnt_a;
    logic                r_gnt_b;
    logic [1:0]          r_page;
    logic                r_page_chg;
    logic [DIGITS_W-1:0] r_digits;
    logic [LED_W-1:0]    r_led;

    logic                w_gnt_a;
    logic                w_gnt_b;
    logic [1:0]          w_page;
    logic                w_chg;
    logic [DIGITS_W-1:0] w_digits;
    logic [LED_W-1:0]    w_led;

    // Two-flop synchronizer plus rising-edge detect on the divided clock
    always_ff @(posedge _50MHz_CLK or posedge RST) begin
        if (RST) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_tick_d <= 1'b0;
        end else begin
            r_sync1  <= tick_in;
            r_sync2  <= r_sync1;
            r_tick_d <= r_sync2;
        end
    end

    assign w_tick    = r_sync2 & ~r_tick_d;
    assign w_expired = (r_hold == HOLD_MAX);

    // State register, round-robin memory and hold counter
    always_ff @(posedge _50MHz_CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_last_b <= 1'b1;
            r_hold   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_hold <= '0;
                if (w_next == ST_A) begin
                    r_last_b <= 1'b0;
                end else if (w_next == ST_B) begin
                    r_last_b <= 1'b1;
                end
            end else if ((r_state != ST_IDLE) && w_tick && !w_expired) begin
                r_hold <= r_hold + HOLD_W'(1);
            end
        end
    end

    // Next-state: drop-out first, then time-slice preemption
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    w_next = r_last_b ? ST_A : ST_B;
                end else if (req_a) begin
                    w_next = ST_A;
                end else if (req_b) begin
                    w_next = ST_B;
                end
            end
            ST_A: begin
                if (!req_a) begin
                    w_next = req_b ? ST_B : ST_IDLE;
                end else if (req_b && w_expired) begin
                    w_next = ST_B;
                end
            end
            ST_B: begin
                if (!req_b) begin
                    w_next = req_a ? ST_A : ST_IDLE;
                end else if (req_a && w_expired) begin
                    w_next = ST_A;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so content and grant move together
    always_comb begin
        w_gnt_a  = 1'b0;
        w_gnt_b  = 1'b0;
        w_page   = 2'd0;
        w_digits = DEFAULT_DIGITS;
        w_led    = DEFAULT_LED;
        w_chg    = (w_next != r_state);
        case (w_next)
            ST_A: begin
                w_gnt_a  = 1'b1;
                w_page   = 2'd1;
                w_digits = dig_a;
                w_led    = led_a;
            end
            ST_B: begin
                w_gnt_b  = 1'b1;
                w_page   = 2'd2;
                w_digits = dig_b;
                w_led    = led_b;
            end
            default: begin
                w_page = 2'd0;
            end
        endcase
    end

    // Output register; page_chg trails the switch edge by one clock
    always_ff @(posedge _50MHz_CLK or posedge RST) begin
        if (RST) begin
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_page     <= 2'd0;
            r_chg      <= 1'b0;
            r_page_chg <= 1'b0;
            r_digits   <= DEFAULT_DIGITS;
            r_led      <= DEFAULT_LED;
        end else begin
            r_gnt_a    <= w_gnt_a;
            r_gnt_b    <= w_gnt_b;
            r_page     <= w_page;
            r_chg      <= w_chg;
            r_page_chg <= r_chg;
            r_digits   <= w_digits;
            r_led      <= w_led;
        end
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign page     = r_page;
    assign page_chg = r_page_chg;
    assign led      = r_led;
    assign seg0     = r_digits[3:0];
    assign seg1     = r_digits[7:4];
    assign seg2     = r_digits[11:8];
    assign seg3     = r_digits[15:12];
    assign seg4     = r_digits[19:16];
    assign seg5     = r_digits[23:20];
    assign seg6     = r_digits[27:24];
    assign seg7     = r_digits[31:28];

endmodule

// File: tb/tb_tm1638_page_sched.sv
// Self-checking bench for tm1638_page_sched: directed scenarios plus a random
// run against a page-level reference model.
module tb_tm1638_page_sched;

    localparam logic [31:0] DEF_DIGITS = 32'h6619_1122;
    localparam logic [7:0]  DEF_LED    = 8'h00;
    localparam int          HOLD       = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ti, ra, rb;
    logic [31:0] da, db;
    logic [7:0]  la, lb;
    logic        gnt_a, gnt_b, page_chg;
    logic [1:0]  page;
    logic [3:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [7:0]  led;
    wire  [31:0] segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: page number, last winner, ticks held, tick_in history
    int          m_page, m_last, m_held;
    bit          m_chg_now, m_chg_out;
    bit          m_hist[3];
    logic [31:0] m_digits;
    logic [7:0]  m_led;

    tm1638_page_sched #(
        .DEFAULT_DIGITS(DEF_DIGITS),
        .DEFAULT_LED   (DEF_LED),
        .MIN_HOLD      (HOLD)
    ) dut (
        ._50MHz_CLK(clk),
        .RST       (rst),
        .tick_in   (ti),
        .req_a     (ra),
        .req_b     (rb),
        .dig_a     (da),
        .dig_b     (db),
        .led_a     (la),
        .led_b     (lb),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .page      (page),
        .page_chg  (page_chg),
        .seg0      (seg0),
        .seg1      (seg1),
        .seg2      (seg2),
        .seg3      (seg3),
        .seg4      (seg4),
        .seg5      (seg5),
        .seg6      (seg6),
        .seg7      (seg7),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_page    = 0;
        m_last    = 2;
        m_held    = 0;
        m_chg_now = 0;
        m_chg_out = 0;
        m_hist    = '{0, 0, 0};
        m_digits  = DEF_DIGITS;
        m_led     = DEF_LED;
    endtask

    // Predict the effect of the coming clock edge with the inputs now applied
    task automatic model_edge();
        bit tick, own, other, expired;
        int nxt, other_page;
        tick    = m_hist[1] && !m_hist[2];
        expired = (m_held >= HOLD);
        nxt     = m_page;
        if (m_page == 0) begin
            if (ra && rb) nxt = (m_last == 1) ? 2 : 1;
            else if (ra) nxt = 1;
            else if (rb) nxt = 2;
        end else begin
            own        = (m_page == 1) ? ra : rb;
            other      = (m_page == 1) ? rb : ra;
            other_page = 3 - m_page;
            if (!own) nxt = other ? other_page : 0;
            else if (other && expired) nxt = other_page;
        end
        if (nxt != m_page) begin
            m_held = 0;
            if (nxt != 0) m_last = nxt;
        end else if (m_page != 0 && tick && m_held < HOLD) begin
            m_held++;
        end
        m_chg_out = m_chg_now;
        m_chg_now = (nxt != m_page);
        m_page    = nxt;
        m_digits  = (nxt == 1) ? da : (nxt == 2) ? db : DEF_DIGITS;
        m_led     = (nxt == 1) ? la : (nxt == 2) ? lb : DEF_LED;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = ti;
    endtask

    // Inputs are applied at the falling edge; returns at the next falling edge
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ra = 0; rb = 0; ti = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (gnt_a !== 0 || gnt_b !== 0 || page !== 0 || page_chg !== 0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt_a=%b gnt_b=%b page=%0d chg=%b, want all 0", gnt_a, gnt_b, page, page_chg);
        end
        n_checks++;
        if (segs !== DEF_DIGITS || led !== DEF_LED) begin
            n_fail++;
            $display("FAIL reset_data: segs=%h led=%h, want %h %h", segs, led, DEF_DIGITS, DEF_LED);
        end
        rb = 1; db = 32'hABCD_0123; lb = 8'h5A;
        step();
        n_checks++;
        if (page !== 2 || gnt_b !== 1) begin
            n_fail++;
            $display("FAIL reset_pregrant: page=%0d gnt_b=%b, want 2 1", page, gnt_b);
        end
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (gnt_b !== 0 || gnt_a !== 0 || page !== 0 || segs !== 32'h6619_1122 || led !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_midgrant: gnt_b=%b page=%0d segs=%h led=%h, want 0 0 66191122 00", gnt_b, page, segs, led);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_request();
        do_reset();
        ra = 1; da = 32'h8765_4321; la = 8'hC3;
        step();
        n_checks++;
        if (gnt_a !== 1 || gnt_b !== 0 || page !== 1 || page_chg !== 0) begin
            n_fail++;
            $display("FAIL single_grant: gnt_a=%b gnt_b=%b page=%0d chg=%b, want 1 0 1 0", gnt_a, gnt_b, page, page_chg);
        end
        n_checks++;
        if (seg0 !== 4'd1 || seg7 !== 4'd8 || segs !== 32'h8765_4321 || led !== 8'hC3) begin
            n_fail++;
            $display("FAIL single_digits: segs=%h led=%h, want 87654321 c3", segs, led);
        end
        step();
        n_checks++;
        if (page_chg !== 1) begin
            n_fail++;
            $display("FAIL single_chg_pulse: page_chg=%b, want 1", page_chg);
        end
        step();
        n_checks++;
        if (page_chg !== 0) begin
            n_fail++;
            $display("FAIL single_chg_end: page_chg=%b, want 0", page_chg);
        end
        ra = 0;
        step();
        n_checks++;
        if (page !== 0 || gnt_a !== 0 || segs !== DEF_DIGITS || led !== DEF_LED) begin
            n_fail++;
            $display("FAIL single_release: page=%0d gnt_a=%b segs=%h, want 0 0 %h", page, gnt_a, segs, DEF_DIGITS);
        end
    endtask

    task automatic test_tie();
        do_reset();
        ra = 1; rb = 1;
        step();
        n_checks++;
        if (page !== 1 || gnt_a !== 1 || gnt_b !== 0) begin
            n_fail++;
            $display("FAIL tie_first: page=%0d gnt_a=%b gnt_b=%b, want 1 1 0", page, gnt_a, gnt_b);
        end
        ra = 0; rb = 0;
        step();
        ra = 1; rb = 1;
        step();
        n_checks++;
        if (page !== 2 || gnt_a !== 0 || gnt_b !== 1) begin
            n_fail++;
            $display("FAIL tie_second: page=%0d gnt_a=%b gnt_b=%b, want 2 0 1", page, gnt_a, gnt_b);
        end
    endtask

    // Tick rises are sampled on edges G+1, G+5, ...; each is counted two edges
    // later, so the 4th count lands on G+15 and preemption on G+16.
    task automatic test_preemption();
        do_reset();
        ra = 1;
        step();
        rb = 1;
        for (int i = 0; i < 32; i++) begin
            ti = ((i % 4) < 2);
            step();
            if (i == 14 || i == 15 || i == 30 || i == 31) begin
                n_checks++;
                if (page !== ((i == 14 || i == 31) ? 2'd1 : 2'd2)) begin
                    n_fail++;
                    $display("FAIL preempt_step%0d: page=%0d, want %0d", i, page, (i == 14 || i == 31) ? 1 : 2);
                end
            end
            n_checks++;
            if (page !== 2'(m_page)) begin
                n_fail++;
                $display("FAIL preempt_model%0d: page=%0d, want %0d", i, page, m_page);
            end
        end
        ti = 0;
    endtask

    task automatic test_handoff();
        do_reset();
        ra = 1;
        step();
        step();
        step();
        ra = 0; rb = 1; db = 32'h0F0F_1234;
        step();
        n_checks++;
        if (page !== 2 || gnt_b !== 1 || gnt_a !== 0 || segs !== 32'h0F0F_1234) begin
            n_fail++;
            $display("FAIL handoff_switch: page=%0d gnt_b=%b segs=%h, want 2 1 0f0f1234", page, gnt_b, segs);
        end
        step();
        n_checks++;
        if (page !== 2 || page_chg !== 1) begin
            n_fail++;
            $display("FAIL handoff_chg: page=%0d chg=%b, want 2 1", page, page_chg);
        end
        step();
        n_checks++;
        if (page_chg !== 0) begin
            n_fail++;
            $display("FAIL handoff_single: chg=%b, want 0", page_chg);
        end
    endtask

    task automatic test_live_data();
        logic [31:0] v;
        logic [7:0]  l;
        do_reset();
        rb = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            v[4*i +: 4] = 4'hF;
            l = 8'($urandom);
            db = v; lb = l;
            step();
            n_checks++;
            if (segs !== v || led !== l) begin
                n_fail++;
                $display("FAIL live_data%0d: segs=%h led=%h, want %h %h", i, segs, led, v, l);
            end
        end
        n_checks++;
        if (seg7 !== 4'hF) begin
            n_fail++;
            $display("FAIL live_nibble_f: seg7=%h, want f", seg7);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) ra = ~ra;
            if ($urandom_range(7) == 0) rb = ~rb;
            if ($urandom_range(2) == 0) ti = ~ti;
            da = $urandom; db = $urandom;
            la = 8'($urandom); lb = 8'($urandom);
            step();
            n_checks++;
            if (page !== 2'(m_page) || gnt_a !== (m_page == 1) || gnt_b !== (m_page == 2) ||
                page_chg !== m_chg_out || segs !== m_digits || led !== m_led) begin
                n_fail++;
                $display("FAIL random%0d: page=%0d ga=%b gb=%b chg=%b segs=%h led=%h, want %0d %b %h %h",
                         i, page, gnt_a, gnt_b, page_chg, segs, led, m_page, m_chg_out, m_digits, m_led);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ti = 0; ra = 0; rb = 0;
        da = '0; db = '0; la = '0; lb = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_request();
        test_tie();
        test_preemption();
        test_handoff();
        test_live_data();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tm1638_page_sched.md
# tm1638_page_sched

Display-page scheduler that shares the single TM1638 8-digit/8-LED front panel between two requesting sources and a built-in default page (the student-ID digits). It sits between the content sources and the `TM1638_config` driver, feeding `seg0`..`seg7` and `led`. Arbitration is round-robin with a minimum on-screen hold measured in ticks of the divided clock from `sw1_2`. When no source requests, the default page is shown.

## Interface
- `DEFAULT_DIGITS`, 32'h6619_1122: default page; `seg0` = bits[3:0] … `seg7` = bits[31:28] (reads 2,2,1,1,9,1,6,6).
- `DEFAULT_LED`, 8'h00: LED pattern on the default page.
- `MIN_HOLD`, 4: minimum ticks a granted page is held before a contending requester preempts it; legal range 1..255.

Ports:
- `_50MHz_CLK` in 1: system clock; all flops on its rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `tick_in` in 1: divided clock level (`Clk_O` of `sw1_2`); asynchronous to the flops' sampling, synchronized internally.
- `req_a`, `req_b` in 1: page requests, level-held while the source wants the display.
- `dig_a`, `dig_b` in 32: source digits, same packing as `DEFAULT_DIGITS`.
- `led_a`, `led_b` in 8: source LED patterns.
- `gnt_a`, `gnt_b` out 1: grant, registered and mutually exclusive.
- `page` out 2: 0 = default, 1 = A, 2 = B; 3 never driven.
- `page_chg` out 1: one-cycle pulse on every page switch.
- `seg0`..`seg7` out 4 each: digit codes to `TM1638_config`. Values are passed through unmodified, including 10..15.
- `led` out 8: LED pattern to `TM1638_config`.

## Operation
- **Tick recovery**
  - `tick_in` passes through a 2-flop synchronizer, then a rising-edge detector.
  - This produces a 1-cycle `tick` pulse.
- **States**
  - IDLE (page 0), GNT_A (page 1), GNT_B (page 2).
  - `last` flag records the most recently granted source.
- **Hold counter**
  - 8 bits, cleared on entry to any GNT state.
  - Increments on each `tick` while in a GNT state.
  - Saturates at `MIN_HOLD`.
  - `expired` = (`hold_cnt` == `MIN_HOLD`).
- **IDLE transitions**
  - Only `req_a` high → GNT_A.
  - Only `req_b` high → GNT_B.
  - Both high → grant the source ≠ `last`.
  - Neither high → stay in IDLE.
- **GNT_X transitions**, with Y the other source, in priority order:
  - `req_X` low and `req_Y` high → GNT_Y.
  - `req_X` low and `req_Y` low → IDLE.
  - `req_X` high, `req_Y` high and `expired` → GNT_Y (time-slice preemption).
  - Otherwise stay in GNT_X.
- **`last` update**: set to X on entry to GNT_X.
- **Output register**
  - `seg*`/`led` load every cycle from the source selected by the *next* state: default parameters, `dig_a`/`led_a`, or `dig_b`/`led_b`.
  - Consequence: display content, `gnt_*` and `page` change on the same edge.
  - While granted, the display tracks live source data.
- **`page_chg`**: high for exactly the cycle after any edge where the state changed.
- **Reset** (asynchronous, any time, including mid-grant):
  - State IDLE, `last` = B (so A wins the first tie).
  - `hold_cnt` = 0, synchronizer and edge flops = 0.
  - `gnt_a` = `gnt_b` = 0, `page` = 0, `page_chg` = 0.
  - `seg*` = `DEFAULT_DIGITS`, `led` = `DEFAULT_LED`.
  - After release, the first transition occurs at the first clock edge.

## Timing
- **Request latency**
  - `req_*` sampled at edge N → `gnt_*`, `page` and `seg*`/`led` valid after edge N.
  - `page_chg` high after edge N+1.
- **Data latency**: source data change at edge N → visible on `seg*`/`led` after edge N (1 register stage).
- **Release latency**: the current requester dropping `req` is acted on at the next edge; there are no dead cycles between GNT_A and GNT_B.
- **Tick latency**: `tick_in` rise → `tick` pulse 3 clocks later. One increment per `tick_in` rising edge, regardless of its high time.
- **Preemption timing**: occurs at the edge after `hold_cnt` reaches `MIN_HOLD` with both requests high. Minimum on-screen time is therefore `MIN_HOLD` tick periods minus synchronizer jitter (≤1 tick).
- **Simultaneous events**
  - A tick at the same edge as a state change does not count toward the new grant.
  - Current `req` dropping and the other `req` rising at the same edge → switch directly, no IDLE cycle.

## Test plan
- **Reset**: assert `RST` mid-GNT_B → same cycle `gnt_b`=0, `page`=0, `seg0..7` = 2,2,1,1,9,1,6,6, `led`=0.
- **Single request**: `req_a`=1 with `dig_a`=32'h8765_4321 → next edge `gnt_a`=1, `page`=1, `seg0`=1…`seg7`=8. `page_chg` pulses once. Drop `req_a` → IDLE and default digits next edge.
- **Tie from IDLE after reset**: `req_a`=`req_b`=1 → GNT_A. Release both, re-raise both → GNT_B (round-robin).
- **Preemption**: `MIN_HOLD`=4, A granted, `req_b` held high. Drive 4 `tick_in` rising edges → switch to GNT_B exactly at the edge after the 4th synchronized tick, not earlier. Then A preempts B after 4 more ticks.
- **Hand-off**: in GNT_A, drop `req_a` and raise `req_b` on the same edge → GNT_B next edge, `page` goes 1→2 with no 0 cycle. Single `page_chg` pulse.
- **Live data and passthrough**: while in GNT_B, change `dig_b` each cycle including nibble 4'hF → `seg*` follows with 1-cycle latency, value 15 passed through unmodified.
